// File: rtl/multicycle_ctrl_hs.sv
// multicycle_ctrl_hs: multicycle MIPS control FSM for variable-latency memory.
// The FSM raises mem_req in FETCH, MEMRD and MEMWR. It holds each of those states
// until mem_ready arrives. If the memory stalls for TIMEOUT cycles, the FSM enters
// a sticky FAULT state that only reset clears.
// Optional feature macro: MC_EXT_OPS_EN adds ADDI (ADDIEX/ADDIWB) and J (JEX).
module multicycle_ctrl_hs #(
  parameter int unsigned TIMEOUT      = 16,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_EXT_OPS_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_FAULT   = 4'd15
  } state_t;

  // Strobes that depend only on the state; they are registered one cycle early
  // from the next state so the outputs leave flops.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       pcen;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       fault;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic ctrl_t base_of(input state_t s);
    ctrl_t c;
    c = ctrl_t'({CTRL_W{1'b0}});
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alusrcb    = 2'b01;
        c.alucontrol = ALU_ADD;
      end
      S_DECODE: begin
        c.alusrcb    = 2'b11;
        c.alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b10;
        c.alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req  = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
      end
      S_RTYPEWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b00;
        c.pcsrc      = 2'b01;
        c.alucontrol = ALU_SUB;
      end
`ifdef MC_EXT_OPS_EN
      S_ADDIEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b10;
        c.alucontrol = ALU_ADD;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
      end
      S_JEX: begin
        c.pcsrc = 2'b10;
        c.pcen  = 1'b1;
      end
`endif
      S_FAULT: begin
        c.fault = 1'b1;
      end
      default: begin
        c = ctrl_t'({CTRL_W{1'b0}});
      end
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         base_q;

  state_t        op_next_s;
  logic          op_bad_s;
  logic [2:0]    alu_funct_s;
  logic          funct_bad_s;

  // Opcode decode: the DECODE successor, or the illegal-instruction outcome.
  always_comb begin
    op_next_s = S_FETCH;
    op_bad_s  = 1'b0;
    case (op)
      OP_LW, OP_SW: op_next_s = S_MEMADR;
      OP_RTYPE:     op_next_s = S_RTYPEEX;
      OP_BEQ:       op_next_s = S_BEQEX;
`ifdef MC_EXT_OPS_EN
      OP_ADDI:      op_next_s = S_ADDIEX;
      OP_J:         op_next_s = S_JEX;
`endif
      default: begin
        op_bad_s  = 1'b1;
        op_next_s = ILLEGAL_TRAP ? S_FAULT : S_FETCH;
      end
    endcase
  end

  // Function-field decode for R-type ALU operations.
  always_comb begin
    alu_funct_s = ALU_AND;
    funct_bad_s = 1'b0;
    case (funct)
      6'b100000: alu_funct_s = ALU_ADD;
      6'b100010: alu_funct_s = ALU_SUB;
      6'b100100: alu_funct_s = ALU_AND;
      6'b100101: alu_funct_s = ALU_OR;
      6'b101010: alu_funct_s = ALU_SLT;
      default:   funct_bad_s = 1'b1;
    endcase
  end

  // Next state and wait counter; memory states hold until mem_ready or timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (state_q == S_MEMRD) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DECODE:  state_d = op_next_s;
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_RTYPEEX: begin
        if (funct_bad_s) begin
          state_d = ILLEGAL_TRAP ? S_FAULT : S_FETCH;
        end else begin
          state_d = S_RTYPEWB;
        end
      end
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
`ifdef MC_EXT_OPS_EN
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
`endif
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
    if (state_d != state_q) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State, wait counter and registered state strobes; reset abandons any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= CNT_ZERO;
      base_q  <= base_of(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_of(state_d);
    end
  end

  // A FETCH commits only in its mem_ready cycle; beq loads the PC only when zero is set.
  assign irwrite    = (state_q == S_FETCH) & mem_ready;
  assign pcen       = base_q.pcen | ((state_q == S_FETCH) & mem_ready) |
                      ((state_q == S_BEQEX) & zero);
  assign alucontrol = (state_q == S_RTYPEEX) ? alu_funct_s : base_q.alucontrol;
  assign illegal    = ((state_q == S_DECODE) & op_bad_s) |
                      ((state_q == S_RTYPEEX) & funct_bad_s);

  assign mem_req  = base_q.mem_req;
  assign memwrite = base_q.memwrite;
  assign regwrite = base_q.regwrite;
  assign alusrca  = base_q.alusrca;
  assign iord     = base_q.iord;
  assign memtoreg = base_q.memtoreg;
  assign regdst   = base_q.regdst;
  assign alusrcb  = base_q.alusrcb;
  assign pcsrc    = base_q.pcsrc;
  assign fault    = base_q.fault;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// tb_multicycle_ctrl_hs: directed scoreboard bench for multicycle_ctrl_hs.
// dut0 uses TIMEOUT=4 and ILLEGAL_TRAP=0. dut1 uses TIMEOUT=4 and ILLEGAL_TRAP=1.
// The stimulus pushes one expected record for each driven cycle. A monitor
// compares each record on the falling edge of that cycle.
module tb_multicycle_ctrl_hs;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;

  logic       mem_req0, memwrite0, pcen0, irwrite0, regwrite0, alusrca0, iord0;
  logic       memtoreg0, regdst0, illegal0, fault0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;
  logic       mem_req1, memwrite1, pcen1, irwrite1, regwrite1, alusrca1, iord1;
  logic       memtoreg1, regdst1, illegal1, fault1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] alucontrol1;
  logic [3:0] state1;

  always #5 clk = ~clk;

  multicycle_ctrl_hs #(.TIMEOUT(4), .ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req0), .memwrite(memwrite0), .pcen(pcen0), .irwrite(irwrite0),
    .regwrite(regwrite0), .alusrca(alusrca0), .iord(iord0), .memtoreg(memtoreg0),
    .regdst(regdst0), .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0),
    .illegal(illegal0), .fault(fault0), .state(state0));

  multicycle_ctrl_hs #(.TIMEOUT(4), .ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req1), .memwrite(memwrite1), .pcen(pcen1), .irwrite(irwrite1),
    .regwrite(regwrite1), .alusrca(alusrca1), .iord(iord1), .memtoreg(memtoreg1),
    .regdst(regdst1), .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(alucontrol1),
    .illegal(illegal1), .fault(fault1), .state(state1));

  // Observed vector: state, then mem_req memwrite pcen irwrite regwrite alusrca iord
  // memtoreg regdst, alusrcb, pcsrc, alucontrol, illegal, fault.
  logic [21:0] obs0, obs1;
  assign obs0 = {state0, mem_req0, memwrite0, pcen0, irwrite0, regwrite0, alusrca0, iord0,
                 memtoreg0, regdst0, alusrcb0, pcsrc0, alucontrol0, illegal0, fault0};
  assign obs1 = {state1, mem_req1, memwrite1, pcen1, irwrite1, regwrite1, alusrca1, iord1,
                 memtoreg1, regdst1, alusrcb1, pcsrc1, alucontrol1, illegal1, fault1};

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX = 4'd8, S_FAULT = 4'd15;

  //                                   mr mw pe ir rw sa io mt rd srcb pcs  alu  il fl
  localparam logic [17:0] O_FETCH_W = 18'b1_0_0_0_0_0_0_0_0_01_00_010_0_0;
  localparam logic [17:0] O_FETCH_R = 18'b1_0_1_1_0_0_0_0_0_01_00_010_0_0;
  localparam logic [17:0] O_DECODE  = 18'b0_0_0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [17:0] O_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_11_00_010_1_0;
  localparam logic [17:0] O_MEMADR  = 18'b0_0_0_0_0_1_0_0_0_10_00_010_0_0;
  localparam logic [17:0] O_MEMRD   = 18'b1_0_0_0_0_0_1_0_0_00_00_000_0_0;
  localparam logic [17:0] O_MEMWB   = 18'b0_0_0_0_1_0_0_1_0_00_00_000_0_0;
  localparam logic [17:0] O_MEMWR   = 18'b1_1_0_0_0_0_1_0_0_00_00_000_0_0;
  localparam logic [17:0] O_R_ADD   = 18'b0_0_0_0_0_1_0_0_0_00_00_010_0_0;
  localparam logic [17:0] O_R_SLT   = 18'b0_0_0_0_0_1_0_0_0_00_00_111_0_0;
  localparam logic [17:0] O_R_ILL   = 18'b0_0_0_0_0_1_0_0_0_00_00_000_1_0;
  localparam logic [17:0] O_RTYPEWB = 18'b0_0_0_0_1_0_0_0_1_00_00_000_0_0;
  localparam logic [17:0] O_BEQ_T   = 18'b0_0_1_0_0_1_0_0_0_00_01_110_0_0;
  localparam logic [17:0] O_BEQ_N   = 18'b0_0_0_0_0_1_0_0_0_00_01_110_0_0;
  localparam logic [17:0] O_FAULT   = 18'b0_0_0_0_0_0_0_0_0_00_00_000_0_1;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLT = 6'b101010, F_BAD = 6'b111111;

  typedef struct {
    int          id;
    logic [21:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input int which, input logic rst_v, input logic rdy_v,
                      input logic [3:0] st, input logic [17:0] o);
    exp_t e;
    reset     = rst_v;
    mem_ready = rdy_v;
    e.id      = step_id;
    e.v       = {st, o};
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: check each queued expectation in the middle of its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if (obs0 !== e.v) begin
        n_fail++;
        $display("FAIL dut0 step%0d: got state=%0d out=%b, expected state=%0d out=%b",
                 e.id, obs0[21:18], obs0[17:0], e.v[21:18], e.v[17:0]);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_checks++;
      if (obs1 !== e.v) begin
        n_fail++;
        $display("FAIL dut1 step%0d: got state=%0d out=%b, expected state=%0d out=%b",
                 e.id, obs1[21:18], obs1[17:0], e.v[21:18], e.v[17:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = OP_LW; funct = F_ADD;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and a wait cycle in FETCH.
    step(0, 1'b0, 1'b0, S_FETCH, O_FETCH_W);

    // lw with mem_ready tied high: five cycles, writeback in the fifth.
    // mem_ready in DECODE, MEMADR and MEMWB must be ignored.
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b1, S_DECODE, O_DECODE);
    step(0, 1'b0, 1'b1, S_MEMADR, O_MEMADR);
    step(0, 1'b0, 1'b1, S_MEMRD,  O_MEMRD);
    step(0, 1'b0, 1'b1, S_MEMWB,  O_MEMWB);

    // sw: three wait cycles. The ready in the fourth cycle (count at TIMEOUT-1)
    // wins over the timeout.
    op = OP_SW;
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b1, S_DECODE, O_DECODE);
    step(0, 1'b0, 1'b0, S_MEMADR, O_MEMADR);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, S_MEMWR, O_MEMWR);
    step(0, 1'b0, 1'b1, S_MEMWR,  O_MEMWR);
    step(0, 1'b0, 1'b0, S_FETCH,  O_FETCH_W);

    // R-type add and slt, then an undecodable funct that pulses illegal and returns to FETCH.
    op = OP_R; funct = F_ADD;
    step(0, 1'b0, 1'b1, S_FETCH,   O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE,  O_DECODE);
    step(0, 1'b0, 1'b0, S_RTYPEEX, O_R_ADD);
    step(0, 1'b0, 1'b0, S_RTYPEWB, O_RTYPEWB);
    funct = F_SLT;
    step(0, 1'b0, 1'b1, S_FETCH,   O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE,  O_DECODE);
    step(0, 1'b0, 1'b0, S_RTYPEEX, O_R_SLT);
    step(0, 1'b0, 1'b0, S_RTYPEWB, O_RTYPEWB);
    funct = F_BAD;
    step(0, 1'b0, 1'b1, S_FETCH,   O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE,  O_DECODE);
    step(0, 1'b0, 1'b0, S_RTYPEEX, O_R_ILL);

    // beq taken, then beq not taken.
    op = OP_BEQ; funct = F_ADD; zero = 1'b1;
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE, O_DECODE);
    step(0, 1'b0, 1'b0, S_BEQEX,  O_BEQ_T);
    zero = 1'b0;
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE, O_DECODE);
    step(0, 1'b0, 1'b0, S_BEQEX,  O_BEQ_N);

    // Illegal opcode in DECODE: illegal pulses and the next state is FETCH.
    op = OP_BAD;
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE, O_DEC_ILL);

    // Reset while MEMWR waits: the access is abandoned and the next cycle is a clean FETCH.
    op = OP_SW;
    step(0, 1'b0, 1'b1, S_FETCH,  O_FETCH_R);
    step(0, 1'b0, 1'b0, S_DECODE, O_DECODE);
    step(0, 1'b0, 1'b0, S_MEMADR, O_MEMADR);
    step(0, 1'b0, 1'b0, S_MEMWR,  O_MEMWR);
    step(0, 1'b1, 1'b0, S_MEMWR,  O_MEMWR);

    // Timeout: four FETCH waits after the reset, then a sticky FAULT that ignores mem_ready.
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b0, S_FETCH, O_FETCH_W);
    step(0, 1'b0, 1'b1, S_FAULT, O_FAULT);
    step(0, 1'b0, 1'b0, S_FAULT, O_FAULT);

    // Trapping instance: an undecodable funct leads to FAULT, and only reset clears it.
    reset = 1'b1;
    @(posedge clk);
    #1;
    op = OP_R; funct = F_BAD;
    step(1, 1'b0, 1'b1, S_FETCH,   O_FETCH_R);
    step(1, 1'b0, 1'b0, S_DECODE,  O_DECODE);
    step(1, 1'b0, 1'b0, S_RTYPEEX, O_R_ILL);
    step(1, 1'b0, 1'b1, S_FAULT,   O_FAULT);
    step(1, 1'b1, 1'b0, S_FAULT,   O_FAULT);
    step(1, 1'b0, 1'b0, S_FETCH,   O_FETCH_W);

    @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d unchecked records, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
